// File: rtl/risc_pkg.sv
// Shared encodings for the multicycle core control path: FSM states, opcodes,
// ALU select codes and datapath mux select values.
package risc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_sel_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU select: fixed ADD/SUB from the FSM, or decoded from
// funct3/funct7b5 for R/I-type execute. Unknown funct3 falls back to ADD.
module alu_decoder
    import risc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output alu_sel_t   alu_sel
);

    always_comb begin
        alu_sel = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_sel = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_sel = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_sel = ALU_SLT;
                    3'b110:  alu_sel = ALU_OR;
                    3'b111:  alu_sel = ALU_AND;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            default: alu_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle core: fetch/decode/execute/memory/writeback.
// Outputs are decoded from state; every output is forced to 0 while rst_n is low.
module multicycle_ctrl
    import risc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] ALU_Sel,
    output logic       illegal_instr
);

    state_t     state_q, state_d;
    logic       mem_req_c, mem_we_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c, illegal_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, aluop_c;
    alu_sel_t   alu_sel_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        illegal_c    = 1'b0;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_REG;
        aluop_c      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + imm here gives the branch/jump target ahead of time
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = SRCA_REG;
                alu_src_b_c = SRCB_IMM;
                state_d     = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a_c = SRCA_REG;
                aluop_c     = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = SRCA_REG;
                alu_src_b_c = SRCB_IMM;
                aluop_c     = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = SRCA_REG;
                aluop_c     = ALUOP_SUB;
                pc_write_c  = zero ^ funct3[0];
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_FOUR;
                pc_write_c  = 1'b1;
                state_d     = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop    (aluop_c),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .op5      (op[5]),
        .alu_sel  (alu_sel_c)
    );

    // Reset lands in FETCH, which would otherwise raise mem_req; gate everything.
    assign mem_req       = rst_n & mem_req_c;
    assign mem_we        = rst_n & mem_we_c;
    assign adr_src       = rst_n & adr_src_c;
    assign ir_write      = rst_n & ir_write_c;
    assign pc_write      = rst_n & pc_write_c;
    assign reg_write     = rst_n & reg_write_c;
    assign illegal_instr = rst_n & illegal_c;
    assign result_src    = rst_n ? result_src_c : 2'b00;
    assign alu_src_a     = rst_n ? alu_src_a_c : 2'b00;
    assign alu_src_b     = rst_n ? alu_src_b_c : 2'b00;
    assign imm_src       = rst_n ? imm_src_of(op) : 2'b00;
    assign ALU_Sel       = rst_n ? alu_sel_c : 3'b000;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, random instruction stream
// against a per-instruction trace model, and a reset-during-write sequence.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] ALU_Sel;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .ALU_Sel(ALU_Sel), .illegal_instr(illegal_instr)
    );

    typedef struct packed {
        logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
        logic [1:0] res, a, b, imm;
        logic [2:0] alu;
    } out_t;

    typedef struct packed {
        logic rdy;
        out_t o;
    } step_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z;
        int         fw, mw, lat, pcw_cnt, rw_cnt, ill_cnt, key_cyc;
        logic [2:0] key_alu;
    } vec_t;

    out_t  act;
    assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal_instr,
                  result_src, alu_src_a, alu_src_b, imm_src, ALU_Sel};

    step_t tr[$];
    int    checks = 0, failures = 0;
    int    cnt_pc, cnt_ir, cnt_rw, cnt_ill;
    logic [2:0] key_seen;

    function automatic logic is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return (o[5] && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic out_t base(input logic [6:0] o);
        out_t r = '0;
        r.imm = imm_of(o);
        return r;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected cycle-by-cycle trace of one instruction, from the instruction class.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int fw, input int mw);
        out_t e;
        tr.delete();
        e = base(o); e.mem_req = 1; e.b = 2'b10; e.res = 2'b10;
        for (int w = 0; w < fw; w++) tr.push_back({1'b0, e});
        e.ir_write = 1; e.pc_write = 1;
        tr.push_back({1'b1, e});
        e = base(o); e.a = 2'b01; e.b = 2'b01; e.illegal = !is_legal(o);
        tr.push_back({rnd_bit(), e});
        if (!is_legal(o)) return;
        if (o == 7'b0000011 || o == 7'b0100011) begin
            e = base(o); e.a = 2'b10; e.b = 2'b01;
            tr.push_back({rnd_bit(), e});
            e = base(o); e.mem_req = 1; e.adr_src = 1; e.mem_we = o[5];
            for (int w = 0; w < mw; w++) tr.push_back({1'b0, e});
            tr.push_back({1'b1, e});
            if (!o[5]) begin
                e = base(o); e.res = 2'b01; e.reg_write = 1;
                tr.push_back({rnd_bit(), e});
            end
        end else if (o == 7'b1100011) begin
            e = base(o); e.a = 2'b10; e.alu = 3'b001; e.pc_write = z ^ f3[0];
            tr.push_back({rnd_bit(), e});
        end else begin
            e = base(o);
            if (o == 7'b1101111) begin
                e.a = 2'b01; e.b = 2'b10; e.pc_write = 1;
            end else begin
                e.a = 2'b10; e.b = (o == 7'b0010011) ? 2'b01 : 2'b00; e.alu = exp_alu(o, f3, f7);
            end
            tr.push_back({rnd_bit(), e});
            e = base(o); e.reg_write = 1;
            tr.push_back({rnd_bit(), e});
        end
    endtask

    task automatic check_out(input string nm, input out_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: outputs got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic run_steps(input string nm, input int n, input int key_cyc);
        cnt_pc = 0; cnt_ir = 0; cnt_rw = 0; cnt_ill = 0; key_seen = 3'bxxx;
        for (int i = 0; i < n; i++) begin
            mem_ready = (i < tr.size()) ? tr[i].rdy : 1'b0;
            @(negedge clk);
            if (i < tr.size()) check_out($sformatf("%s cyc%0d", nm, i), tr[i].o);
            else check_int($sformatf("%s extra cycle %0d beyond trace", nm, i), i, tr.size() - 1);
            cnt_pc  += int'(act.pc_write);
            cnt_ir  += int'(act.ir_write);
            cnt_rw  += int'(act.reg_write);
            cnt_ill += int'(act.illegal);
            if (i == key_cyc) key_seen = act.alu;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_fetch(input string nm);
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (!(act.mem_req && act.a == 2'b00 && act.b == 2'b10 && act.res == 2'b10 &&
              !act.ir_write && !act.reg_write && !act.mem_we)) begin
            failures++;
            $display("FAIL %s: not back in fetch, outputs got %h", nm, act);
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs[12];
    logic [6:0] rop;
    out_t e;

    initial begin
        //           op          f3     f7 z  fw mw lat pcw rw ill key alu
        vecs[0]  = '{7'b0000011, 3'b010, 0, 0, 2, 1, 8, 1, 1, 0, 4, 3'b000}; // lw with waits
        vecs[1]  = '{7'b0000011, 3'b010, 0, 0, 0, 0, 5, 1, 1, 0, 2, 3'b000}; // lw
        vecs[2]  = '{7'b0100011, 3'b010, 0, 0, 0, 0, 4, 1, 0, 0, 2, 3'b000}; // sw
        vecs[3]  = '{7'b1100011, 3'b000, 0, 1, 0, 0, 3, 2, 0, 0, 2, 3'b001}; // beq taken
        vecs[4]  = '{7'b1100011, 3'b001, 0, 1, 0, 0, 3, 1, 0, 0, 2, 3'b001}; // bne not taken
        vecs[5]  = '{7'b0110011, 3'b000, 1, 0, 0, 0, 4, 1, 1, 0, 2, 3'b001}; // sub
        vecs[6]  = '{7'b0010011, 3'b000, 1, 0, 0, 0, 4, 1, 1, 0, 2, 3'b000}; // addi, f7b5=1
        vecs[7]  = '{7'b0110011, 3'b010, 0, 0, 0, 0, 4, 1, 1, 0, 2, 3'b101}; // slt
        vecs[8]  = '{7'b0110011, 3'b110, 0, 0, 0, 0, 4, 1, 1, 0, 2, 3'b011}; // or
        vecs[9]  = '{7'b0010011, 3'b111, 0, 0, 0, 0, 4, 1, 1, 0, 2, 3'b010}; // andi
        vecs[10] = '{7'b1101111, 3'b000, 0, 0, 0, 0, 4, 2, 1, 0, 2, 3'b000}; // jal
        vecs[11] = '{7'b1111111, 3'b000, 0, 0, 0, 0, 2, 1, 0, 1, 1, 3'b000}; // illegal

        rst_n = 1'b0; op = 7'b0100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        mem_ready = 1'b1;
        #3 check_out("reset outputs", '0);
        @(posedge clk); #1;
        check_out("reset outputs after edge", '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            op = vecs[k].op; funct3 = vecs[k].f3; funct7b5 = vecs[k].f7; zero = vecs[k].z;
            build(vecs[k].op, vecs[k].f3, vecs[k].f7, vecs[k].z, vecs[k].fw, vecs[k].mw);
            run_steps($sformatf("vec%0d", k), vecs[k].lat, vecs[k].key_cyc);
            check_int($sformatf("vec%0d ir_write count", k), cnt_ir, 1);
            check_int($sformatf("vec%0d pc_write count", k), cnt_pc, vecs[k].pcw_cnt);
            check_int($sformatf("vec%0d reg_write count", k), cnt_rw, vecs[k].rw_cnt);
            check_int($sformatf("vec%0d illegal count", k), cnt_ill, vecs[k].ill_cnt);
            check_int($sformatf("vec%0d key ALU_Sel", k), int'(key_seen), int'(vecs[k].key_alu));
            check_fetch($sformatf("vec%0d end", k));
        end

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: rop = 7'b0000011;
                1: rop = 7'b0100011;
                2: rop = 7'b0110011;
                3: rop = 7'b0010011;
                4: rop = 7'b1100011;
                5: rop = 7'b1101111;
                default: begin
                    rop = 7'($urandom_range(0, 127));
                    while (is_legal(rop)) rop = 7'($urandom_range(0, 127));
                end
            endcase
            op = rop; funct3 = 3'($urandom_range(0, 7)); funct7b5 = rnd_bit(); zero = rnd_bit();
            build(op, funct3, funct7b5, zero, $urandom_range(0, 3), $urandom_range(0, 3));
            run_steps($sformatf("rand%0d op=%b", n, rop), tr.size(), -1);
        end
        check_fetch("random stream end");

        // sw stalled in MEMWRITE, then reset asserted mid-cycle
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        build(op, funct3, funct7b5, zero, 0, 3);
        run_steps("sw stall", 4, -1);
        mem_ready = 1'b0;
        @(negedge clk);
        check_out("memwrite still waiting", tr[4].o);
        #1 rst_n = 1'b0;
        #1 check_out("reset drops memwrite", '0);
        @(posedge clk); #1;
        check_out("held in reset", '0);
        rst_n = 1'b1;
        e = base(op); e.mem_req = 1; e.b = 2'b10; e.res = 2'b10;
        @(negedge clk);
        check_out("fetch after reset", e);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
